laser_driver: RTL and testbench

Host-side companion to the LASER circle-placement engine. Buffers a 40-object frame from an upstream valid/ready source and replays it onto the engine's `X`/`Y` load bus using the engine's reset-then-stream protocol. It then waits for the engine's `DONE` pulse and captures the two circle centres. Optionally, it scores how many objects those centres cover and returns the result through a valid/ready result port. It sits between the frame source and the LASER instance in the top-level datapath.

---
 rtl/laser_driver_pkg.sv | 24 ++
 rtl/laser_cover_unit.sv | 46 ++++
 rtl/laser_driver.sv | 199 +++++++++++++++++++
 tb/tb_laser_driver.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/laser_driver_pkg.sv
// rtl/laser_driver_pkg.sv - shared constants, types and FSM encoding for the LASER host driver
//
// Purpose: common definitions imported by laser_driver and laser_cover_unit.
//   N_OBJ_C   objects per frame fixed by the engine load protocol
//   RAD_SQ    squared coverage radius (radius 4)
//   coord_t   4-bit object / centre coordinate
//   drv_state_t driver FSM states
package laser_driver_pkg;

  localparam int         N_OBJ_C = 40;
  localparam logic [8:0] RAD_SQ  = 9'd16;

  typedef logic [3:0] coord_t;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_RSTP,
    ST_FEED,
    ST_WAIT,
    ST_SCORE,
    ST_RESULT
  } drv_state_t;

endpackage

// File: rtl/laser_cover_unit.sv
// rtl/laser_cover_unit.sv - combinational test of one object against two circle centres
//
// Purpose: flags an object lying within radius 4 (squared distance <= 16) of
// either centre. Only instantiated when LASER_DRV_SCORE_EN is defined.
// Ports:
//   px, py    in  4  object coordinates
//   c1x, c1y  in  4  first circle centre
//   c2x, c2y  in  4  second circle centre
//   covered   out 1  object inside at least one circle
module laser_cover_unit
  import laser_driver_pkg::*;
(
  input  logic [3:0] px,
  input  logic [3:0] py,
  input  logic [3:0] c1x,
  input  logic [3:0] c1y,
  input  logic [3:0] c2x,
  input  logic [3:0] c2y,
  output logic       covered
);

  function automatic logic [3:0] abs_diff(input coord_t a, input coord_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Squares are widened to 9 bits before summing so 15^2 + 15^2 cannot wrap.
  function automatic logic [8:0] dist_sq(input coord_t ax, input coord_t ay,
                                         input coord_t bx, input coord_t by);
    logic [8:0] dx;
    logic [8:0] dy;
    dx = 9'(abs_diff(ax, bx));
    dy = 9'(abs_diff(ay, by));
    return (dx * dx) + (dy * dy);
  endfunction

  logic [8:0] d1;
  logic [8:0] d2;

  always_comb begin
    d1      = dist_sq(px, py, c1x, c1y);
    d2      = dist_sq(px, py, c2x, c2y);
    // An object inside both circles still yields a single covered bit.
    covered = (d1 <= RAD_SQ) || (d2 <= RAD_SQ);
  end

endmodule

// File: rtl/laser_driver.sv
// rtl/laser_driver.sv - buffers a 40-object frame, replays it to the LASER engine and returns the centres
//
// Purpose: LOAD -> RSTP -> FEED -> WAIT -> (SCORE) -> RESULT -> LOAD.
// Optional feature macro: LASER_DRV_SCORE_EN adds the SCORE state and the
// coverage count; without it RES_COUNT is tied to 0.
// Ports:
//   CLK, RST_N                        clock, asynchronous active-low reset
//   LD_VALID, LD_READY, LD_X, LD_Y    upstream object load handshake
//   L_RST, L_X, L_Y                   engine reset and object stream
//   L_C1X, L_C1Y, L_C2X, L_C2Y        engine circle centres
//   L_DONE                            engine completion pulse
//   RES_VALID, RES_READY              result handshake
//   RES_C1X..RES_C2Y, RES_COUNT       captured centres and coverage count
//   RES_TIMEOUT                       engine never signalled DONE
module laser_driver
  import laser_driver_pkg::*;
#(
  parameter int N_OBJ     = N_OBJ_C,
  parameter int TIMEOUT_W = 20
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       LD_VALID,
  output logic       LD_READY,
  input  logic [3:0] LD_X,
  input  logic [3:0] LD_Y,
  output logic       L_RST,
  output logic [3:0] L_X,
  output logic [3:0] L_Y,
  input  logic [3:0] L_C1X,
  input  logic [3:0] L_C1Y,
  input  logic [3:0] L_C2X,
  input  logic [3:0] L_C2Y,
  input  logic       L_DONE,
  output logic       RES_VALID,
  input  logic       RES_READY,
  output logic [3:0] RES_C1X,
  output logic [3:0] RES_C1Y,
  output logic [3:0] RES_C2X,
  output logic [3:0] RES_C2Y,
  output logic [5:0] RES_COUNT,
  output logic       RES_TIMEOUT
);

  localparam int                   PW        = $clog2(N_OBJ);
  localparam logic [PW-1:0]        LAST_IDX  = PW'(N_OBJ - 1);
  // Timeout is taken on the wait cycle whose increment makes the counter all-ones.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  drv_state_t           state;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        rd_next;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [3:0]           mem_x [0:N_OBJ-1];
  logic [3:0]           mem_y [0:N_OBJ-1];
  logic [3:0]           l_x_q;
  logic [3:0]           l_y_q;
  logic [3:0]           c1x_q, c1y_q, c2x_q, c2y_q;
  logic                 timeout_q;

  assign rd_next = rd_ptr + PW'(1);

  // Frame buffer carries no reset: its contents only matter after a full load.
  always_ff @(posedge CLK) begin
    if (state == ST_LOAD && LD_VALID) begin
      mem_x[wr_ptr] <= LD_X;
      mem_y[wr_ptr] <= LD_Y;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_LOAD;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wait_cnt  <= '0;
      l_x_q     <= '0;
      l_y_q     <= '0;
      c1x_q     <= '0;
      c1y_q     <= '0;
      c2x_q     <= '0;
      c2y_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (LD_VALID) begin
            if (wr_ptr == LAST_IDX) begin
              wr_ptr <= '0;
              state  <= ST_RSTP;
            end else begin
              wr_ptr <= wr_ptr + PW'(1);
            end
          end
        end
        ST_RSTP: begin
          // Preload object 0 so it is on the bus for the whole first FEED cycle.
          rd_ptr   <= '0;
          wait_cnt <= '0;
          l_x_q    <= mem_x[0];
          l_y_q    <= mem_y[0];
          state    <= ST_FEED;
        end
        ST_FEED: begin
          if (rd_ptr == LAST_IDX) begin
            rd_ptr <= '0;
            state  <= ST_WAIT;
          end else begin
            rd_ptr <= rd_next;
            l_x_q  <= mem_x[rd_next];
            l_y_q  <= mem_y[rd_next];
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + TIMEOUT_W'(1);
          if (L_DONE) begin
            c1x_q <= L_C1X;
            c1y_q <= L_C1Y;
            c2x_q <= L_C2X;
            c2y_q <= L_C2Y;
`ifdef LASER_DRV_SCORE_EN
            state <= ST_SCORE;
`else
            state <= ST_RESULT;
`endif
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_q <= 1'b1;
            c1x_q     <= '0;
            c1y_q     <= '0;
            c2x_q     <= '0;
            c2y_q     <= '0;
            state     <= ST_RESULT;
          end
        end
`ifdef LASER_DRV_SCORE_EN
        ST_SCORE: begin
          if (rd_ptr == LAST_IDX) begin
            rd_ptr <= '0;
            state  <= ST_RESULT;
          end else begin
            rd_ptr <= rd_next;
          end
        end
`endif
        ST_RESULT: begin
          if (RES_READY) begin
            wr_ptr    <= '0;
            timeout_q <= 1'b0;
            state     <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

`ifdef LASER_DRV_SCORE_EN
  logic       covered;
  logic [5:0] res_cnt;

  laser_cover_unit u_cover (
    .px      (mem_x[rd_ptr]),
    .py      (mem_y[rd_ptr]),
    .c1x     (c1x_q),
    .c1y     (c1y_q),
    .c2x     (c2x_q),
    .c2y     (c2y_q),
    .covered (covered)
  );

  // Cleared at the start of every frame, so a timed-out frame reports 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      res_cnt <= '0;
    end else if (state == ST_RSTP) begin
      res_cnt <= '0;
    end else if (state == ST_SCORE) begin
      res_cnt <= res_cnt + 6'(covered);
    end
  end

  assign RES_COUNT = res_cnt;
`else
  assign RES_COUNT = '0;
`endif

  assign LD_READY    = (state == ST_LOAD);
  assign L_RST       = !((state == ST_FEED) || (state == ST_WAIT));
  assign L_X         = l_x_q;
  assign L_Y         = l_y_q;
  assign RES_VALID   = (state == ST_RESULT);
  assign RES_C1X     = c1x_q;
  assign RES_C1Y     = c1y_q;
  assign RES_C2X     = c2x_q;
  assign RES_C2Y     = c2y_q;
  assign RES_TIMEOUT = timeout_q;

endmodule

// File: tb/tb_laser_driver.sv
// tb/tb_laser_driver.sv - directed table-driven bench for laser_driver
module tb_laser_driver;

`ifdef LASER_DRV_SCORE_EN
  localparam int SCORE_CYC = 40;
  localparam bit SCORE_ON  = 1'b1;
`else
  localparam int SCORE_CYC = 0;
  localparam bit SCORE_ON  = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       LD_VALID;
  logic       LD_READY;
  logic [3:0] LD_X, LD_Y;
  logic       L_RST;
  logic [3:0] L_X, L_Y;
  logic [3:0] L_C1X, L_C1Y, L_C2X, L_C2Y;
  logic       L_DONE;
  logic       RES_VALID;
  logic       RES_READY;
  logic [3:0] RES_C1X, RES_C1Y, RES_C2X, RES_C2Y;
  logic [5:0] RES_COUNT;
  logic       RES_TIMEOUT;
  logic [15:0] cen_drv;

  assign {L_C1X, L_C1Y, L_C2X, L_C2Y} = cen_drv;

  always #5 CLK = ~CLK;

  laser_driver #(.N_OBJ(40), .TIMEOUT_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_X(LD_X), .LD_Y(LD_Y),
    .L_RST(L_RST), .L_X(L_X), .L_Y(L_Y),
    .L_C1X(L_C1X), .L_C1Y(L_C1Y), .L_C2X(L_C2X), .L_C2Y(L_C2Y),
    .L_DONE(L_DONE),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_C1X(RES_C1X), .RES_C1Y(RES_C1Y), .RES_C2X(RES_C2X), .RES_C2Y(RES_C2Y),
    .RES_COUNT(RES_COUNT), .RES_TIMEOUT(RES_TIMEOUT)
  );

  typedef struct {
    int          pat;       // object pattern
    logic [15:0] cen;       // {c1x,c1y,c2x,c2y} returned by the engine model
    int          done_dly;  // WAIT cycle on which DONE is pulsed, 0 = never
    int          hold;      // cycles of RES_READY=0 backpressure
    int          exp_cnt;   // hand-computed coverage count
  } frame_t;

  frame_t tbl [4];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] obj(input int pat, input int k);
    logic [7:0] v;
    case (pat)
      0:       v = {4'(k % 16), 4'(k / 16)};
      1:       v = (k == 0) ? 8'h00 : (k == 1) ? 8'h33 : (k == 2) ? 8'hFB : 8'h88;
      default: v = 8'h55;
    endcase
    return v;
  endfunction

  task automatic load_frame(input int pat);
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (k == 0) check("ld_ready_load", 32'(LD_READY), 32'd1);
      LD_VALID = 1'b1;
      {LD_X, LD_Y} = obj(pat, k);
    end
    // Keep offering junk: it must be ignored outside LOAD.
    @(negedge CLK);
    {LD_X, LD_Y} = 8'hFF;
    check("rstp_state", {L_RST, LD_READY}, {1'b1, 1'b0});
  endtask

  task automatic run_frame(input frame_t f);
    int  c;
    bit  got;
    int  exp_lat;
    logic [15:0] exp_cen;
    logic        exp_to;
    load_frame(f.pat);
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      check($sformatf("feed_k%0d", k), {L_RST, L_X, L_Y}, {1'b0, obj(f.pat, k)});
    end
    cen_drv = f.cen;
    c   = 1;
    got = 0;
    while (c <= 300) begin
      @(negedge CLK);
      if (RES_VALID) begin
        got = 1;
        break;
      end
      if (c == 1) check("wait_hold", {L_RST, L_X, L_Y}, {1'b0, obj(f.pat, 39)});
      L_DONE = (f.done_dly == c);
      c++;
    end
    L_DONE  = 1'b0;
    cen_drv = ~f.cen;
    exp_to  = (f.done_dly == 0);
    exp_lat = exp_to ? 15 : f.done_dly + SCORE_CYC;
    exp_cen = exp_to ? 16'h0 : f.cen;
    check("result_seen", 32'(got), 32'd1);
    check("result_latency", c - 1, exp_lat);
    repeat (f.hold) @(negedge CLK);
    check("res_centres", {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}, exp_cen);
    check("res_count", 32'(RES_COUNT), SCORE_ON ? f.exp_cnt : 0);
    check("res_flags", {RES_VALID, RES_TIMEOUT, LD_READY, L_RST}, {1'b1, exp_to, 1'b0, 1'b1});
    RES_READY = 1'b1;
    LD_VALID  = 1'b0;
    @(negedge CLK);
    RES_READY = 1'b0;
    check("back_to_load", {RES_VALID, RES_TIMEOUT, LD_READY, L_RST}, {1'b0, 1'b0, 1'b1, 1'b1});
  endtask

  initial begin
    // C1=(0,0) covers 13 of the grid objects, C2=(15,2) covers 8 more.
    tbl[0] = '{pat: 0, cen: 16'h00F2, done_dly: 3,  hold: 0,   exp_cnt: 21};
    tbl[1] = '{pat: 1, cen: 16'h9999, done_dly: 0,  hold: 5,   exp_cnt: 0};
    // (0,0) and (3,3) hit C1=(4,0), (15,11) hits C2=(15,15), (8,8) hits neither.
    tbl[2] = '{pat: 1, cen: 16'h40FF, done_dly: 1,  hold: 100, exp_cnt: 3};
    // DONE on the last allowed wait cycle must beat the timeout.
    tbl[3] = '{pat: 2, cen: 16'h5555, done_dly: 15, hold: 2,   exp_cnt: 40};

    RST_N = 1'b0; LD_VALID = 1'b0; LD_X = '0; LD_Y = '0;
    L_DONE = 1'b0; RES_READY = 1'b0; cen_drv = '0;
    repeat (2) @(negedge CLK);
    check("reset_outputs", {LD_READY, L_RST, L_X, L_Y, RES_VALID, RES_TIMEOUT},
          {1'b1, 1'b1, 8'h00, 1'b0, 1'b0});
    check("reset_results", {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y, 2'b00, RES_COUNT}, 24'h0);
    RST_N = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 4; i++) run_frame(tbl[i]);

    // Asynchronous reset in the middle of FEED, then a clean frame.
    load_frame(0);
    repeat (21) @(negedge CLK);
    check("feed_k20_before_rst", {L_RST, L_X, L_Y}, {1'b0, obj(0, 20)});
    #2 RST_N = 1'b0;
    #1;
    check("midfeed_rst_outputs", {LD_READY, L_RST, L_X, L_Y, RES_VALID, RES_TIMEOUT},
          {1'b1, 1'b1, 8'h00, 1'b0, 1'b0});
    check("midfeed_rst_results", {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y, 2'b00, RES_COUNT}, 24'h0);
    LD_VALID = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    run_frame(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
